lsu_mem_sched: RTL

- Sequences the single data-memory port behind the LSU issue queue.
- Accepts one issued load/store uop at a time and back-pressures the queue with stall_lsuq.
- Arbitrates the port between issued loads and committed-store drains from the store buffer.
- Returns completions (load data, store done, exceptions) to the CDB/ROB.

---
 rtl/lsu_mem_sched.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_sched.sv
// lsu_mem_sched: single data-memory port sequencer behind the LSU issue queue.
// Takes one issued load/store at a time, arbitrates the port between loads and
// committed-store drains, and returns completions to the CDB/ROB.
//
// Handshake rules:
//   issue : a uop is taken when iss_valid && !stall_lsuq && !flush; the queue
//           must hold the uop while stall_lsuq is high.
//   memory: at most one outstanding request. The request is taken when
//           mem_req && mem_gnt, and its fields stay stable until then. Exactly
//           one mem_rvalid answers each granted request (a write ack for stores).
module lsu_mem_sched #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  output logic        stall_lsuq,
  input  logic        iss_valid,
  input  logic [5:0]  iss_Px,
  input  logic [31:0] iss_Addr,
  input  logic [3:0]  iss_Conf,
  input  logic        iss_RegWr,
  input  logic [5:0]  iss_tag_rob,
  input  logic        iss_has_excp,
  input  logic        sb_valid,
  input  logic [31:0] sb_addr,
  input  logic [31:0] sb_data,
  input  logic [3:0]  sb_mask,
  output logic        sb_pop,
  input  logic        ld_conflict,
  output logic [31:0] lookup_addr,
  output logic        st_alloc,
  output logic [5:0]  st_alloc_tag,
  output logic [31:0] st_alloc_addr,
  output logic [5:0]  st_alloc_Px,
  output logic [3:0]  st_alloc_mask,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_RegWr,
  output logic [5:0]  wb_Pd,
  output logic [31:0] wb_data,
  output logic [5:0]  wb_tag_rob,
  output logic        wb_excp,
  output logic [2:0]  dbg_state
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LD_REQ     = 3'd1,
    LD_WAIT    = 3'd2,
    ST_REQ     = 3'd3,
    ST_WAIT    = 3'd4,
    WB         = 3'd5,
    FLUSH_WAIT = 3'd6
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   starve_cnt;
  logic            ld_pending;
  logic [5:0]      h_px, h_tag;
  logic [31:0]     h_addr, h_data;
  logic [2:0]      h_conf;
  logic            h_regwr, h_excp;
  logic            drain_sel, accept, iss_misaligned, in_wb;
  logic [31:0]     ld_shift, ld_ext;
  logic [3:0]      alloc_mask;
  logic            unused_conf;

  // Conf[3] is reserved and carries no meaning here.
  assign unused_conf = iss_Conf[3];

  assign drain_sel  = (state == IDLE) && sb_valid && (!iss_valid || starve_cnt == STARVE_LIM);
  assign stall_lsuq = (state != IDLE) || drain_sel;
  assign accept     = iss_valid && !stall_lsuq && !flush;
  assign in_wb      = (state == WB);
  assign dbg_state  = state;

  // Half needs bit 0 clear; word (and the unused size code) needs both low bits clear.
  assign iss_misaligned = ((iss_Conf[1:0] == 2'b01) && iss_Addr[0]) ||
                          (iss_Conf[1] && (iss_Addr[1:0] != 2'b00));

  // Align the returned word to the held address, then zero- or sign-extend.
  always_comb begin
    ld_shift = mem_rdata >> {h_addr[1:0], 3'b000};
    case (h_conf[1:0])
      2'b00:   ld_ext = {{24{~h_conf[2] & ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_ext = {{16{~h_conf[2] & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Byte-lane mask of the held store for the store-buffer allocation.
  always_comb begin
    alloc_mask = 4'b1111;
    case (h_conf[1:0])
      2'b00:   alloc_mask = 4'b0001 << h_addr[1:0];
      2'b01:   alloc_mask = h_addr[1] ? 4'b1100 : 4'b0011;
      default: alloc_mask = 4'b1111;
    endcase
  end

  // Next-state selection; flush rules decide whether a response must be swallowed.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (flush)          state_nx = IDLE;
        else if (drain_sel) state_nx = ST_REQ;
        else if (accept) begin
          if (iss_has_excp || iss_misaligned) state_nx = WB;
          else if (iss_RegWr)                 state_nx = LD_REQ;
          else                                state_nx = WB;
        end
      end
      LD_REQ: begin
        if (flush)            state_nx = (mem_req && mem_gnt) ? FLUSH_WAIT : IDLE;
        else if (ld_conflict) state_nx = ST_REQ;
        else if (mem_gnt)     state_nx = LD_WAIT;
      end
      LD_WAIT: begin
        if (mem_rvalid) state_nx = flush ? IDLE : WB;
        else if (flush) state_nx = FLUSH_WAIT;
      end
      ST_REQ:     if (mem_gnt) state_nx = ST_WAIT;
      ST_WAIT:    if (mem_rvalid) state_nx = (ld_pending && !flush) ? LD_REQ : IDLE;
      WB:         state_nx = IDLE;
      FLUSH_WAIT: if (mem_rvalid) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Memory request and store-buffer pop, decoded from the registered state.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    sb_pop    = 1'b0;
    case (state)
      LD_REQ: begin
        if (!ld_conflict) begin
          mem_req  = 1'b1;
          mem_addr = {h_addr[31:2], 2'b00};
        end
      end
      ST_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sb_addr;
        mem_wdata = sb_data;
        mem_wstrb = sb_mask;
        sb_pop    = mem_gnt;
      end
      default: ;
    endcase
  end

  // Completion and allocation outputs come from the held uop; a flush cancels them.
  assign wb_valid      = in_wb && !flush;
  assign wb_RegWr      = in_wb && h_regwr;
  assign wb_Pd         = in_wb ? h_px : 6'h0;
  assign wb_data       = in_wb ? h_data : 32'h0;
  assign wb_tag_rob    = in_wb ? h_tag : 6'h0;
  assign wb_excp       = in_wb && h_excp;
  assign st_alloc      = in_wb && !h_regwr && !h_excp && !flush;
  assign st_alloc_tag  = st_alloc ? h_tag : 6'h0;
  assign st_alloc_addr = st_alloc ? h_addr : 32'h0;
  assign st_alloc_Px   = st_alloc ? h_px : 6'h0;
  assign st_alloc_mask = st_alloc ? alloc_mask : 4'h0;
  assign lookup_addr   = h_addr;

  // State, holding register, starvation counter and pending-load flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ld_pending <= 1'b0;
      h_px       <= 6'h0;
      h_tag      <= 6'h0;
      h_addr     <= 32'h0;
      h_data     <= 32'h0;
      h_conf     <= 3'h0;
      h_regwr    <= 1'b0;
      h_excp     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        h_px    <= iss_Px;
        h_tag   <= iss_tag_rob;
        h_addr  <= iss_Addr;
        h_conf  <= iss_Conf[2:0];
        h_regwr <= iss_RegWr;
        h_excp  <= iss_has_excp || iss_misaligned;
        h_data  <= 32'h0;
      end else if (state == LD_WAIT && mem_rvalid) begin
        h_data <= ld_ext;
      end
      if (state == LD_REQ && ld_conflict && !flush)
        ld_pending <= 1'b1;
      else if (flush || (state == ST_WAIT && mem_rvalid))
        ld_pending <= 1'b0;
      if (state_nx == ST_REQ && state != ST_REQ)
        starve_cnt <= '0;
      else if (state == IDLE && sb_valid && !drain_sel && starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
